// File: rtl/axil_write_arbiter.sv
// Two-master, one-slave AXI4-Lite write arbiter with round-robin grant held until the B handshake.
// Define AXIL_ARB_DECERR_EN to terminate writes outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) locally with DECERR.
module axil_write_arbiter #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0000_1000
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        m0_AWVALID,
    output logic        m0_AWREADY,
    input  logic [31:0] m0_AWADDR,
    input  logic        m0_WVALID,
    output logic        m0_WREADY,
    input  logic [31:0] m0_WDATA,
    input  logic [3:0]  m0_WSTRB,
    output logic        m0_BVALID,
    input  logic        m0_BREADY,
    output logic [1:0]  m0_BRESP,
    input  logic        m1_AWVALID,
    output logic        m1_AWREADY,
    input  logic [31:0] m1_AWADDR,
    input  logic        m1_WVALID,
    output logic        m1_WREADY,
    input  logic [31:0] m1_WDATA,
    input  logic [3:0]  m1_WSTRB,
    output logic        m1_BVALID,
    input  logic        m1_BREADY,
    output logic [1:0]  m1_BRESP,
    output logic        s_AWVALID,
    output logic [31:0] s_AWADDR,
    input  logic        s_AWREADY,
    output logic        s_WVALID,
    output logic [31:0] s_WDATA,
    output logic [3:0]  s_WSTRB,
    input  logic        s_WREADY,
    input  logic        s_BVALID,
    input  logic [1:0]  s_BRESP,
    output logic        s_BREADY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
`ifdef AXIL_ARB_DECERR_EN
        RESP  = 2'd2,
        LRESP = 2'd3
`else
        RESP  = 2'd2
`endif
    } state_t;

    state_t state, state_nxt;
    logic   grant, grant_nxt;
    logic   prio, prio_nxt;
    logic   aw_done, aw_done_nxt;
    logic   w_done, w_done_nxt;
    logic   aw_hs, w_hs;

    // Signals of whichever master currently holds the grant.
    logic        g_awvalid, g_wvalid, g_bready;
    logic [31:0] g_awaddr, g_wdata;
    logic [3:0]  g_wstrb;
    logic        g_awready, g_wready, g_bvalid;
    logic [1:0]  g_bresp;

    assign g_awvalid = grant ? m1_AWVALID : m0_AWVALID;
    assign g_awaddr  = grant ? m1_AWADDR  : m0_AWADDR;
    assign g_wvalid  = grant ? m1_WVALID  : m0_WVALID;
    assign g_wdata   = grant ? m1_WDATA   : m0_WDATA;
    assign g_wstrb   = grant ? m1_WSTRB   : m0_WSTRB;
    assign g_bready  = grant ? m1_BREADY  : m0_BREADY;

`ifdef AXIL_ARB_DECERR_EN
    logic err, err_nxt;

    // Offset compare avoids overflow of ADDR_BASE + ADDR_SIZE at the top of the map.
    function automatic logic out_of_range(input logic [31:0] addr);
        return (addr < ADDR_BASE) || ((addr - ADDR_BASE) >= ADDR_SIZE);
    endfunction
`else
    logic unused_cfg;
    assign unused_cfg = ^{ADDR_BASE, ADDR_SIZE};
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nxt   = state;
        grant_nxt   = grant;
        prio_nxt    = prio;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
`ifdef AXIL_ARB_DECERR_EN
        err_nxt     = err;
`endif
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        s_AWVALID   = 1'b0;
        s_AWADDR    = '0;
        s_WVALID    = 1'b0;
        s_WDATA     = '0;
        s_WSTRB     = '0;
        s_BREADY    = 1'b0;
        g_awready   = 1'b0;
        g_wready    = 1'b0;
        g_bvalid    = 1'b0;
        g_bresp     = 2'b00;

        case (state)
            IDLE: begin
                if (m0_AWVALID || m1_AWVALID) begin
                    grant_nxt   = (m0_AWVALID && m1_AWVALID) ? prio : m1_AWVALID;
                    state_nxt   = XFER;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
`ifdef AXIL_ARB_DECERR_EN
                    err_nxt     = out_of_range(grant_nxt ? m1_AWADDR : m0_AWADDR);
`endif
                end
            end
            XFER: begin
`ifdef AXIL_ARB_DECERR_EN
                if (err) begin
                    g_awready = ~aw_done;
                    g_wready  = ~w_done;
                end else begin
`else
                begin
`endif
                    s_AWVALID = g_awvalid & ~aw_done;
                    s_AWADDR  = g_awaddr;
                    s_WVALID  = g_wvalid & ~w_done;
                    s_WDATA   = g_wdata;
                    s_WSTRB   = g_wstrb;
                    g_awready = s_AWREADY & ~aw_done;
                    g_wready  = s_WREADY & ~w_done;
                end
                aw_hs       = g_awvalid & g_awready;
                w_hs        = g_wvalid & g_wready;
                aw_done_nxt = aw_done | aw_hs;
                w_done_nxt  = w_done | w_hs;
                if (aw_done_nxt && w_done_nxt) begin
`ifdef AXIL_ARB_DECERR_EN
                    state_nxt = err ? LRESP : RESP;
`else
                    state_nxt = RESP;
`endif
                end
            end
            RESP: begin
                g_bvalid = s_BVALID;
                g_bresp  = s_BRESP;
                s_BREADY = g_bready;
                if (s_BVALID && g_bready) begin
                    state_nxt = IDLE;
                    prio_nxt  = ~grant;
                end
            end
`ifdef AXIL_ARB_DECERR_EN
            LRESP: begin
                g_bvalid = 1'b1;
                g_bresp  = 2'b11;
                if (g_bready) begin
                    state_nxt = IDLE;
                    prio_nxt  = ~grant;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: reset is sampled on the clock edge only, so it lives inside the clocked branch.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state   <= IDLE;
            grant   <= 1'b0;
            prio    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifdef AXIL_ARB_DECERR_EN
            err     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            prio    <= prio_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
`ifdef AXIL_ARB_DECERR_EN
            err     <= err_nxt;
`endif
        end
    end

    // The non-granted master always sees idle handshakes and OKAY.
    assign m0_AWREADY = ~grant & g_awready;
    assign m1_AWREADY =  grant & g_awready;
    assign m0_WREADY  = ~grant & g_wready;
    assign m1_WREADY  =  grant & g_wready;
    assign m0_BVALID  = ~grant & g_bvalid;
    assign m1_BVALID  =  grant & g_bvalid;
    assign m0_BRESP   = grant ? 2'b00 : g_bresp;
    assign m1_BRESP   = grant ? g_bresp : 2'b00;

endmodule

// File: tb/tb_axil_write_arbiter.sv
// Directed self-checking bench for axil_write_arbiter; the DECERR cases run only when
// AXIL_ARB_DECERR_EN is defined for both bench and design.
module tb_axil_write_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        m0_AWVALID, m0_AWREADY, m0_WVALID, m0_WREADY, m0_BVALID, m0_BREADY;
    logic [31:0] m0_AWADDR, m0_WDATA;
    logic [3:0]  m0_WSTRB;
    logic [1:0]  m0_BRESP;
    logic        m1_AWVALID, m1_AWREADY, m1_WVALID, m1_WREADY, m1_BVALID, m1_BREADY;
    logic [31:0] m1_AWADDR, m1_WDATA;
    logic [3:0]  m1_WSTRB;
    logic [1:0]  m1_BRESP;
    logic        s_AWVALID, s_AWREADY, s_WVALID, s_WREADY, s_BVALID, s_BREADY;
    logic [31:0] s_AWADDR, s_WDATA;
    logic [3:0]  s_WSTRB;
    logic [1:0]  s_BRESP;

    int n_checks = 0;
    int n_fails  = 0;
    int aw_beats = 0;
    int w_beats  = 0;
    int aw_snap, w_snap;

    logic [12:0] out_vec;
    assign out_vec = {m0_AWREADY, m1_AWREADY, m0_WREADY, m1_WREADY, m0_BVALID, m1_BVALID,
                      m0_BRESP, m1_BRESP, s_AWVALID, s_WVALID, s_BREADY};

    axil_write_arbiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .m0_AWVALID(m0_AWVALID), .m0_AWREADY(m0_AWREADY), .m0_AWADDR(m0_AWADDR),
        .m0_WVALID(m0_WVALID), .m0_WREADY(m0_WREADY), .m0_WDATA(m0_WDATA), .m0_WSTRB(m0_WSTRB),
        .m0_BVALID(m0_BVALID), .m0_BREADY(m0_BREADY), .m0_BRESP(m0_BRESP),
        .m1_AWVALID(m1_AWVALID), .m1_AWREADY(m1_AWREADY), .m1_AWADDR(m1_AWADDR),
        .m1_WVALID(m1_WVALID), .m1_WREADY(m1_WREADY), .m1_WDATA(m1_WDATA), .m1_WSTRB(m1_WSTRB),
        .m1_BVALID(m1_BVALID), .m1_BREADY(m1_BREADY), .m1_BRESP(m1_BRESP),
        .s_AWVALID(s_AWVALID), .s_AWADDR(s_AWADDR), .s_AWREADY(s_AWREADY),
        .s_WVALID(s_WVALID), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WREADY(s_WREADY),
        .s_BVALID(s_BVALID), .s_BRESP(s_BRESP), .s_BREADY(s_BREADY)
    );

    always #5 ACLK = ~ACLK;

    // Slave-side beat counters, used to prove exactly one AW and one W beat per write.
    always @(posedge ACLK) begin
        if (s_AWVALID && s_AWREADY) aw_beats <= aw_beats + 1;
        if (s_WVALID && s_WREADY)   w_beats  <= w_beats + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic smp();
        @(negedge ACLK);
    endtask

    task automatic clear_inputs();
        m0_AWVALID = 1'b0; m0_AWADDR = '0; m0_WVALID = 1'b0; m0_WDATA = '0; m0_WSTRB = '0; m0_BREADY = 1'b0;
        m1_AWVALID = 1'b0; m1_AWADDR = '0; m1_WVALID = 1'b0; m1_WDATA = '0; m1_WSTRB = '0; m1_BREADY = 1'b0;
        s_AWREADY = 1'b0; s_WREADY = 1'b0; s_BVALID = 1'b0; s_BRESP = 2'b00;
    endtask

    task automatic do_reset();
        clear_inputs();
        ARESETn = 1'b0;
        cyc();
        ARESETn = 1'b1;
    endtask

    initial begin
        clear_inputs();
        ARESETn = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;

        // Single write from m0; cycle 1 is IDLE, s_AWVALID must appear in cycle 2.
        m0_AWVALID = 1'b1; m0_AWADDR = 32'h10; m0_WVALID = 1'b1;
        m0_WDATA = 32'hA5A5_A5A5; m0_WSTRB = 4'hF; m0_BREADY = 1'b1;
        s_AWREADY = 1'b1; s_WREADY = 1'b1;
        smp();
        check("reset_outputs_zero", 32'(out_vec), 0);
        cyc();
        smp();
        check("single_s_awvalid_c2", 32'(s_AWVALID), 1);
        check("single_s_awaddr", s_AWADDR, 32'h10);
        check("single_s_wvalid", 32'(s_WVALID), 1);
        check("single_s_wdata", s_WDATA, 32'hA5A5_A5A5);
        check("single_s_wstrb", 32'(s_WSTRB), 32'hF);
        check("single_awready_m1m0", 32'({m1_AWREADY, m0_AWREADY}), 1);
        cyc();
        m0_AWVALID = 1'b0; m0_WVALID = 1'b0; s_BVALID = 1'b1; s_BRESP = 2'b00;
        smp();
        check("single_m0_b", 32'({m0_BVALID, m0_BRESP, s_BREADY}), 9);
        check("single_m1_quiet", 32'({m1_AWREADY, m1_WREADY, m1_BVALID, m1_BRESP}), 0);
        cyc();
        s_BVALID = 1'b0;
        smp();
        check("single_back_idle", 32'(out_vec), 0);

        // Contention: both masters request continuously; round-robin from prio = 0 after reset.
        cyc();
        do_reset();
        m0_AWVALID = 1'b1; m0_AWADDR = 32'h100; m0_WVALID = 1'b1; m0_WDATA = 32'h1111_0000; m0_WSTRB = 4'h3; m0_BREADY = 1'b1;
        m1_AWVALID = 1'b1; m1_AWADDR = 32'h200; m1_WVALID = 1'b1; m1_WDATA = 32'h2222_0000; m1_WSTRB = 4'hC; m1_BREADY = 1'b1;
        s_AWREADY = 1'b1; s_WREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("cont_idle_no_ready", 32'({m1_AWREADY, m0_AWREADY}), 0);
            cyc();
            smp();
            check("cont_grant", 32'({m1_AWREADY, m0_AWREADY}), (i % 2 == 1) ? 2 : 1);
            check("cont_addr", s_AWADDR, (i % 2 == 1) ? 32'h200 : 32'h100);
            check("cont_wstrb", 32'(s_WSTRB), (i % 2 == 1) ? 32'hC : 32'h3);
            cyc();
            if (i % 2 == 1) begin m1_AWVALID = 1'b0; m1_WVALID = 1'b0; end
            else begin m0_AWVALID = 1'b0; m0_WVALID = 1'b0; end
            s_BVALID = 1'b1;
            smp();
            check("cont_bvalid", 32'({m1_BVALID, m0_BVALID}), (i % 2 == 1) ? 2 : 1);
            check("cont_no_aw_in_resp", 32'({m1_AWREADY, m0_AWREADY, s_AWVALID}), 0);
            cyc();
            s_BVALID = 1'b0;
            m0_AWVALID = 1'b1; m0_WVALID = 1'b1; m1_AWVALID = 1'b1; m1_WVALID = 1'b1;
        end
        clear_inputs();

        // W presented 3 cycles before AW: no request, W held off.
        m1_WVALID = 1'b1; m1_WDATA = 32'hCAFE_0001; m1_WSTRB = 4'hF; m1_BREADY = 1'b1;
        s_AWREADY = 1'b1; s_WREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            check("w_early_held", 32'({m1_WREADY, s_WVALID, s_AWVALID}), 0);
            cyc();
        end
        m1_AWVALID = 1'b1; m1_AWADDR = 32'h300;
        aw_snap = aw_beats; w_snap = w_beats;
        smp();
        cyc();
        smp();
        check("w_early_xfer", 32'({s_AWVALID, s_WVALID, m1_AWREADY, m1_WREADY}), 15);
        cyc();
        m1_AWVALID = 1'b0; m1_WVALID = 1'b0; s_BVALID = 1'b1;
        smp();
        check("w_early_aw_beats", 32'(aw_beats - aw_snap), 1);
        check("w_early_w_beats", 32'(w_beats - w_snap), 1);
        check("w_early_resp", 32'(m1_BVALID), 1);
        cyc();
        clear_inputs();

        // Slave accepts W two cycles before AW.
        m0_AWVALID = 1'b1; m0_AWADDR = 32'h400; m0_WVALID = 1'b1; m0_WDATA = 32'hBEEF_0002; m0_WSTRB = 4'h5; m0_BREADY = 1'b1;
        s_WREADY = 1'b1;
        aw_snap = aw_beats; w_snap = w_beats;
        smp();
        cyc();
        smp();
        check("w_first_xfer", 32'({s_AWVALID, s_WVALID, m0_AWREADY, m0_WREADY}), 13);
        cyc();
        smp();
        check("w_first_wdone", 32'({s_AWVALID, s_WVALID, m0_WREADY, s_BREADY, m0_BVALID}), 16);
        cyc();
        smp();
        check("w_first_stall", 32'({s_AWVALID, s_WVALID, m0_WREADY, s_BREADY, m0_BVALID}), 16);
        cyc();
        s_AWREADY = 1'b1;
        smp();
        check("w_first_awready", 32'({m0_AWREADY, m0_BVALID}), 2);
        cyc();
        m0_AWVALID = 1'b0; m0_WVALID = 1'b0; s_BVALID = 1'b1;
        smp();
        check("w_first_aw_beats", 32'(aw_beats - aw_snap), 1);
        check("w_first_w_beats", 32'(w_beats - w_snap), 1);
        check("w_first_resp", 32'(m0_BVALID), 1);
        cyc();
        clear_inputs();

        // Back-pressure on B with SLVERR while m1 waits.
        m0_AWVALID = 1'b1; m0_AWADDR = 32'h500; m0_WVALID = 1'b1; m0_WDATA = 32'h5; m0_WSTRB = 4'hF;
        s_AWREADY = 1'b1; s_WREADY = 1'b1;
        smp();
        cyc();
        smp();
        cyc();
        m0_AWVALID = 1'b0; m0_WVALID = 1'b0; s_BVALID = 1'b1; s_BRESP = 2'b10;
        m1_AWVALID = 1'b1; m1_AWADDR = 32'h600; m1_WVALID = 1'b1; m1_WDATA = 32'h6; m1_WSTRB = 4'hF;
        for (int i = 0; i < 5; i++) begin
            smp();
            check("bp_b_stable", 32'({m0_BVALID, m0_BRESP, s_BREADY, m1_AWREADY, m1_BVALID, m1_BRESP}), 32'hC0);
            cyc();
        end
        m0_BREADY = 1'b1;
        smp();
        check("bp_s_bready", 32'({s_BREADY, m0_BRESP}), 6);
        cyc();
        s_BVALID = 1'b0; s_BRESP = 2'b00; m0_BREADY = 1'b0;
        smp();
        check("bp_idle_bubble", 32'(out_vec), 0);
        cyc();
        smp();
        check("bp_m1_granted", 32'({m1_AWREADY, m0_AWREADY}), 2);
        check("bp_m1_addr", s_AWADDR, 32'h600);
        cyc();

        // Reset while m1 waits in RESP: the write is abandoned.
        m1_AWVALID = 1'b0; m1_WVALID = 1'b0; s_BVALID = 1'b1;
        smp();
        check("rst_pre_bvalid", 32'(m1_BVALID), 1);
        cyc();
        ARESETn = 1'b0;
        smp();
        cyc();
        ARESETn = 1'b1; m1_BREADY = 1'b1;
        smp();
        check("rst_outputs_zero", 32'(out_vec), 0);
        check("rst_awaddr_zero", s_AWADDR, 0);
        cyc();
        s_BVALID = 1'b0;
        m1_AWVALID = 1'b1; m1_AWADDR = 32'h700; m1_WVALID = 1'b1; m1_WDATA = 32'h7;
        smp();
        check("rst_idle", 32'(out_vec), 0);
        cyc();
        smp();
        check("rst_m1_granted", 32'({m1_AWREADY, m0_AWREADY}), 2);
        check("rst_m1_addr", s_AWADDR, 32'h700);
        cyc();
        m1_AWVALID = 1'b0; m1_WVALID = 1'b0; s_BVALID = 1'b1;
        smp();
        check("rst_m1_b", 32'({m1_BVALID, m1_BRESP}), 4);
        cyc();
        clear_inputs();

`ifdef AXIL_ARB_DECERR_EN
        // Out-of-window write is completed locally with DECERR.
        m0_AWVALID = 1'b1; m0_AWADDR = 32'h2000; m0_WVALID = 1'b1; m0_WDATA = 32'hDEAD; m0_WSTRB = 4'hF;
        s_AWREADY = 1'b1; s_WREADY = 1'b1;
        aw_snap = aw_beats; w_snap = w_beats;
        smp();
        cyc();
        smp();
        check("dec_xfer", 32'({s_AWVALID, s_WVALID, m0_AWREADY, m0_WREADY}), 3);
        cyc();
        m0_AWVALID = 1'b0; m0_WVALID = 1'b0;
        smp();
        check("dec_lresp_hold", 32'({m0_BVALID, m0_BRESP, s_BREADY}), 14);
        cyc();
        m0_BREADY = 1'b1;
        smp();
        check("dec_lresp", 32'({m0_BVALID, m0_BRESP, s_BREADY}), 14);
        cyc();
        m0_BREADY = 1'b0;
        smp();
        check("dec_no_slave_aw", 32'(aw_beats - aw_snap), 0);
        check("dec_no_slave_w", 32'(w_beats - w_snap), 0);
        check("dec_back_idle", 32'(out_vec), 0);

        // Last word of the window is forwarded.
        cyc();
        m0_AWVALID = 1'b1; m0_AWADDR = 32'h0FFC; m0_WVALID = 1'b1; m0_BREADY = 1'b1;
        smp();
        cyc();
        smp();
        check("dec_edge_fwd", 32'({s_AWVALID, s_WVALID}), 3);
        check("dec_edge_addr", s_AWADDR, 32'h0FFC);
        cyc();
        m0_AWVALID = 1'b0; m0_WVALID = 1'b0; s_BVALID = 1'b1;
        smp();
        check("dec_edge_b", 32'({m0_BVALID, m0_BRESP}), 4);
        cyc();
        clear_inputs();
`endif

        smp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/axil_write_arbiter.md
# axil_write_arbiter

Two-master to one-slave arbiter for the AXI4-Lite write path (AW, W, B channels). It sits between two write-address/write-data masters and a single write slave such as the register slave. It grants the slave to one master per transaction using round-robin. It holds the grant from AW/W acceptance until the B handshake completes. Optionally, it terminates out-of-range writes locally with DECERR.

## Interface
- ADDR_BASE, 32'h0000_0000, lowest slave byte address (used only with the decode feature)
- ADDR_SIZE, 32'h0000_1000, slave window size in bytes; in range = ADDR_BASE <= AWADDR < ADDR_BASE+ADDR_SIZE
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  reset; synchronous, active-low
- m0_AWVALID, m1_AWVALID  in  1  master write-address valid
- m0_AWREADY, m1_AWREADY  out  1  address accepted
- m0_AWADDR, m1_AWADDR  in  32  write address
- m0_WVALID, m1_WVALID  in  1  write-data valid
- m0_WREADY, m1_WREADY  out  1  data accepted
- m0_WDATA, m1_WDATA  in  32  write data
- m0_WSTRB, m1_WSTRB  in  4  byte strobes
- m0_BVALID, m1_BVALID  out  1  response valid
- m0_BREADY, m1_BREADY  in  1  response accepted
- m0_BRESP, m1_BRESP  out  2  response code
- s_AWVALID / s_AWADDR  out  1 / 32  to slave
- s_AWREADY  in  1  from slave
- s_WVALID / s_WDATA / s_WSTRB  out  1 / 32 / 4  to slave
- s_WREADY  in  1  from slave
- s_BVALID / s_BRESP  in  1 / 2  from slave
- s_BREADY  out  1  to slave

## Operation
- States: IDLE, XFER, RESP, plus LRESP (decode feature only). Registers: state, grant (0/1), prio (next preferred master), aw_done, w_done.
- IDLE: all m_*READY, m_BVALID, s_*VALID and s_BREADY are 0. Request = mX_AWVALID.
  - Only one master requesting: grant it.
  - Both requesting: grant prio.
  - Grant and state are registered; next state is XFER; aw_done and w_done are cleared.
- XFER: slave AW/W signals come combinationally from the granted master. s_AWVALID = m_AWVALID & ~aw_done. s_WVALID = m_WVALID & ~w_done. Granted m_AWREADY = s_AWREADY & ~aw_done; m_WREADY likewise.
  - A handshake sets the matching *_done flag.
  - AW and W may complete in either order or in the same cycle.
  - Once both are done (flags or same-cycle handshakes), next state is RESP.
- RESP: s_BVALID and s_BRESP route to the granted master; s_BREADY = granted m_BREADY. On B handshake: state becomes IDLE and prio becomes ~grant.
- The non-granted master sees AWREADY = WREADY = BVALID = 0, BRESP = 2'b00 in every state.
- m_BRESP is 2'b00 except when driven from the slave or from LRESP.
- WDATA/WSTRB are passed through unmodified.

## Timing
- Reset (ARESETn = 0 at a rising edge):
  - state = IDLE, prio = 0, grant = 0, done flags = 0.
  - All outputs are 0 from the following cycle.
  - Reset mid-transaction abandons it; no B is returned.
- Grant latency: AWVALID first seen high in IDLE at cycle N gives s_AWVALID high in cycle N+1.
- Minimum transaction is 3 cycles: IDLE, XFER (AW and W same cycle), RESP (BVALID and BREADY same cycle).
- Back-to-back: after a B handshake in cycle N, the next grant is sampled in cycle N+1 (IDLE). There is one bubble cycle.
- WVALID without AWVALID does not request. W is held off (WREADY = 0) until granted.
- Stall in XFER or RESP is unbounded; the grant never changes before the B handshake.

## Configuration
- AXIL_ARB_DECERR_EN defined:
  - At grant, the arbiter registers err = granted AWADDR outside the window.
  - If err is set, XFER keeps s_AWVALID = s_WVALID = 0 and drives granted m_AWREADY = m_WREADY = 1 until both are done.
  - The arbiter then enters LRESP: m_BVALID = 1, m_BRESP = 2'b11, held until m_BREADY; then IDLE with prio toggled.
  - The slave sees no traffic for these writes.
- Not defined: ADDR_BASE/ADDR_SIZE are ignored, every write is forwarded, and LRESP does not exist.

## Test plan
- Single write: m0 AWADDR 32'h10, WDATA 32'hA5A5_A5A5, WSTRB 4'hF, slave ready and BRESP 2'b00 -> s_AWVALID in cycle 2, m0_BVALID with BRESP 00; m1 outputs stay 0.
- Contention: m0 and m1 assert AWVALID/WVALID together, repeated 4 times -> grant order m0, m1, m0, m1; each grant is held until its B handshake.
- Channel ordering: W valid 3 cycles before AW; also the case with s_WREADY before s_AWREADY -> exactly one slave W beat and one AW beat; RESP entered only after both.
- Back-pressure: slave holds BVALID for 5 cycles with m0_BREADY = 0, BRESP 2'b10 -> m0 sees BVALID/BRESP 10 stable; m1 is not granted until the B handshake.
- Reset: ARESETn low during RESP -> next cycle IDLE, all outputs 0; then an m1-only request is granted normally.
- With AXIL_ARB_DECERR_EN, ADDR_SIZE 32'h1000: AWADDR 32'h2000 -> no s_AWVALID/s_WVALID, m_BRESP 2'b11; AWADDR 32'h0FFC -> forwarded to the slave.
